// File: rtl/stack_bank_controller.sv
// stack_bank_controller: three push/pop stacks (8/16/32-bit wide) behind one decoder port,
// with sticky overflow/underflow flags and a DEPTH-cycle clear sequence that zeroes storage.
module stack_bank_controller #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        STACK_pop_flag,
   input  logic [1:0]  STACK_pop_id,
   input  logic        STACK_write_back_flag,
   input  logic [7:0]  STACK_write_back_code,
   input  logic [31:0] STACK_write_back_value,
   input  logic        clear_req,
   output logic [7:0]  STACK_TOP_A,
   output logic [15:0] STACK_TOP_B,
   output logic [31:0] STACK_TOP_C,
   output logic [7:0]  STACK_AMOUNT_A,
   output logic [7:0]  STACK_AMOUNT_B,
   output logic [7:0]  STACK_AMOUNT_C,
   output logic        busy,
   output logic [2:0]  err_overflow,
   output logic [2:0]  err_underflow
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] DEP = 8'(DEPTH);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t state_q, state_d;
   logic [7:0] idx_q, idx_d;
   logic [2:0][7:0] amt_q, amt_d;
   logic [2:0] ov_q, ov_d, un_q, un_d;
   logic [2:0] pop_s, push_s, push_ok;
   logic [AW-1:0] top_ix [3];
   logic [7:0]  mem_a [DEPTH];
   logic [15:0] mem_b [DEPTH];
   logic [31:0] mem_c [DEPTH];
   logic accept;
   assign cmd_ready = (state_q == IDLE) && !clear_req;
   assign accept    = cmd_valid && cmd_ready;
   // pop wins over write-back; pop_id 0 and unknown codes decode to nothing
   assign pop_s  = (accept && STACK_pop_flag) ?
                   {STACK_pop_id == 2'd3, STACK_pop_id == 2'd2, STACK_pop_id == 2'd1} : 3'b000;
   assign push_s = (accept && !STACK_pop_flag && STACK_write_back_flag) ?
                   {STACK_write_back_code == 8'h60, STACK_write_back_code == 8'h40,
                    STACK_write_back_code == 8'h20} : 3'b000;
   assign push_ok = push_s & {amt_q[2] != DEP, amt_q[1] != DEP, amt_q[0] != DEP};
   always_comb begin
      for (int k = 0; k < 3; k++) top_ix[k] = AW'(amt_q[k] - 8'd1);
   end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      amt_d   = amt_q;
      ov_d    = ov_q;
      un_d    = un_q;
      if (state_q == CLEAR) begin
         idx_d   = (idx_q == DEP - 8'd1) ? 8'd0 : idx_q + 8'd1;
         state_d = (idx_q == DEP - 8'd1) ? IDLE : CLEAR;
      end else if (clear_req) begin
         state_d = CLEAR;
         idx_d   = 8'd0;
         amt_d   = '0;
         ov_d    = 3'b000;
         un_d    = 3'b000;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (pop_s[k]) begin
               un_d[k]  = un_q[k] | (amt_q[k] == 8'd0);
               amt_d[k] = (amt_q[k] == 8'd0) ? amt_q[k] : amt_q[k] - 8'd1;
            end
            if (push_s[k]) begin
               ov_d[k]  = ov_q[k] | !push_ok[k];
               amt_d[k] = push_ok[k] ? amt_q[k] + 8'd1 : amt_q[k];
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= 8'd0;
         amt_q   <= '0;
         ov_q    <= 3'b000;
         un_q    <= 3'b000;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         amt_q   <= amt_d;
         ov_q    <= ov_d;
         un_q    <= un_d;
      end
   end
   // storage has no reset; an empty stack reads 0 through the amount check
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem_a[idx_q[AW-1:0]] <= 8'd0;
         mem_b[idx_q[AW-1:0]] <= 16'd0;
         mem_c[idx_q[AW-1:0]] <= 32'd0;
      end else begin
         if (push_ok[0]) mem_a[amt_q[0][AW-1:0]] <= STACK_write_back_value[7:0];
         if (push_ok[1]) mem_b[amt_q[1][AW-1:0]] <= STACK_write_back_value[15:0];
         if (push_ok[2]) mem_c[amt_q[2][AW-1:0]] <= STACK_write_back_value;
      end
   end
   assign STACK_TOP_A    = (amt_q[0] != 8'd0) ? mem_a[top_ix[0]] : 8'd0;
   assign STACK_TOP_B    = (amt_q[1] != 8'd0) ? mem_b[top_ix[1]] : 16'd0;
   assign STACK_TOP_C    = (amt_q[2] != 8'd0) ? mem_c[top_ix[2]] : 32'd0;
   assign STACK_AMOUNT_A = amt_q[0];
   assign STACK_AMOUNT_B = amt_q[1];
   assign STACK_AMOUNT_C = amt_q[2];
   assign busy           = (state_q == CLEAR);
   assign err_overflow   = ov_q;
   assign err_underflow  = un_q;
endmodule

// File: doc/stack_bank_controller.md
STACK_BANK_CONTROLLER -- requirements
Module: stack_bank_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entries per stack (2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  decoder command present this cycle.
REQ-005 SHALL have port cmd_ready  output  1  command accepted this cycle (combinational).
REQ-006 SHALL have port STACK_pop_flag  input  1  pop request.
REQ-007 SHALL have port STACK_pop_id  input  2  target stack; 1=A, 2=B, 3=C, 0=none.
REQ-008 SHALL have port STACK_write_back_flag  input  1  write-back request.
REQ-009 SHALL have port STACK_write_back_code  input  8  push target; 0x20=A, 0x40=B, 0x60=C.
REQ-010 SHALL have port STACK_write_back_value  input  32  push data.
REQ-011 SHALL have port clear_req  input  1  start a full clear of all stacks.
REQ-012 SHALL have ports STACK_TOP_A / _B / _C  outputs  8 / 16 / 32  current top entry per stack.
REQ-013 SHALL have ports STACK_AMOUNT_A / _B / _C  outputs  8 each  entry count per stack.
REQ-014 SHALL have port busy  output  1  clear sequence in progress.
REQ-015 SHALL have port err_overflow  output  3  sticky per stack; bit0=A, bit1=B, bit2=C.
REQ-016 SHALL have port err_underflow  output  3  sticky per stack; same bit order.

Function
REQ-017 SHALL implement FSM states IDLE and CLEAR; reset enters IDLE.
REQ-018 SHALL drive cmd_ready = (state==IDLE) && !clear_req.
REQ-019 SHALL decode, when cmd_valid && cmd_ready, as follows:
- POP: STACK_pop_flag=1 and pop_id!=0.
- PUSH: STACK_pop_flag=0, STACK_write_back_flag=1 and code in {0x20,0x40,0x60}.
- Anything else (including pop_id=0 and other write-back codes): no-op.
REQ-020 SHALL give POP priority when STACK_pop_flag and STACK_write_back_flag are both 1.
REQ-021 SHALL, on PUSH with amount<DEPTH:
- write the value truncated to the stack width (A [7:0], B [15:0], C [31:0]) at index amount;
- increment amount at the same edge.
REQ-022 SHALL, on PUSH with amount==DEPTH: leave storage and amount unchanged and set the stack's err_overflow bit.
REQ-023 SHALL, on POP with amount>0: decrement amount at the same edge; storage is unchanged.
REQ-024 SHALL, on POP with amount==0: leave amount unchanged and set the stack's err_underflow bit.
REQ-025 SHALL drive STACK_TOP_x combinationally as entry[amount-1] when amount>0, else 0.
- The decoder samples the old top in the same cycle a POP is issued.
REQ-026 SHALL make amount and top changes visible the cycle after acceptance (1-cycle latency).
REQ-027 SHALL, on clear_req in IDLE:
- enter CLEAR and assert busy from the next cycle;
- zero all three amounts and both error vectors at the entering edge.
REQ-028 SHALL, in CLEAR, zero entry index i of all three stacks per cycle, i=0..DEPTH-1.
- Return to IDLE after i==DEPTH-1, so busy is high for exactly DEPTH cycles.
REQ-029 SHALL ignore clear_req while in CLEAR (no restart).
REQ-030 SHALL drop a command presented in the same cycle as clear_req; cmd_ready=0 that cycle.
REQ-031 SHALL confine each operation to its target stack; the other two stacks are untouched.

Reset
REQ-032 SHALL, on reset (priority over all other inputs, including mid-CLEAR), set:
- state to IDLE;
- all amounts to 0, busy to 0, err_overflow and err_underflow to 0, all tops to 0.
REQ-033 SHALL NOT require storage contents to be cleared by reset; tops read 0 because amounts are 0.

Verification
REQ-034 SHALL cover: PUSH A 0x1AB, then PUSH A 0x05 -> STACK_TOP_A=0x05, AMOUNT_A=2; POP A -> TOP_A=0xAB, AMOUNT_A=1.
REQ-035 SHALL cover: 16 PUSHes to C (DEPTH=16), then a 17th PUSH -> AMOUNT_C=16, err_overflow=3'b100, TOP_C = 16th value.
REQ-036 SHALL cover: POP B on empty -> err_underflow=3'b010, AMOUNT_B=0, TOP_B=0.
REQ-037 SHALL cover: clear_req with cmd_valid PUSH B in the same cycle -> cmd_ready=0, busy high 16 cycles, AMOUNT_B=0 afterwards, errors cleared.
REQ-038 SHALL cover: reset asserted at CLEAR cycle 5 -> next cycle busy=0, state IDLE, cmd_ready=1.
REQ-039 SHALL cover: GSA-style command (pop_flag=0, write_back_flag=1, code 0x07) -> no state change in any stack.
